// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock, LSB digit first.
// Optional subtract mode is enabled with the DIGIT_SERIAL_ADDER_SUB_EN macro (adds port Sub).
module digit_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CNTW = (NDIG > 1) ? $clog2(NDIG) : 1;

    if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
        $error("digit_serial_adder: DIGIT must be >= 1 and divide WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNTW-1:0]  cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             cout_q, ovf_q;

    logic             accept;
    logic             last_digit;
    logic [DIGIT-1:0] dsum;
    logic [DIGIT:0]   chain;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // Subtract is A + ~B + 1; Cin is ignored in that mode.
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    assign b_load = Sub ? ~B : B;
    assign c_load = Sub ? 1'b1 : Cin;
`else
    assign b_load = B;
    assign c_load = Cin;
`endif

    assign accept     = (state_q == StIdle) && in_valid;
    assign last_digit = (cnt_q == CNTW'(NDIG - 1));

    // One digit's ripple chain of full-adder cells.
    always_comb begin
        chain    = '0;
        dsum     = '0;
        chain[0] = carry_q;
        for (int i = 0; i < int'(DIGIT); i++) begin
            dsum[i]    = a_q[i] ^ b_q[i] ^ chain[i];
            chain[i+1] = (a_q[i] & b_q[i]) | (chain[i] & (a_q[i] ^ b_q[i]));
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StRun;
            StRun:   if (last_digit) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        Sum       = sum_q;
        Cout      = cout_q;
        Ovf       = ovf_q;
    end

    // Datapath: operand/result shift registers, digit counter, carry and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= A;
                b_q     <= b_load;
                carry_q <= c_load;
                cnt_q   <= '0;
            end else if (state_q == StRun) begin
                a_q     <= a_q >> DIGIT;
                b_q     <= b_q >> DIGIT;
                sum_q   <= (sum_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
                carry_q <= chain[DIGIT];
                cnt_q   <= cnt_q + 1'b1;
                if (last_digit) begin
                    cout_q <= chain[DIGIT];
                    ovf_q  <= chain[DIGIT] ^ chain[DIGIT-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder (WIDTH=16, DIGIT=4); covers Sub when
// DIGIT_SERIAL_ADDER_SUB_EN is defined.
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A, B;
    logic        Cin;
    logic        sub_s;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Sum;
    logic        Cout;
    logic        Ovf;

    int total = 0;
    int bad   = 0;

    digit_serial_adder #(
        .WIDTH (16),
        .DIGIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        .Sub       (sub_s),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition of A, the (possibly inverted) B and carry-in.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub);
        logic [16:0] full;
        logic [15:0] bb;
        logic        c0;
        logic        exp_ovf;
        int          n;
        bb      = sub ? ~b : b;
        c0      = sub ? 1'b1 : cin;
        full    = {1'b0, a} + {1'b0, bb} + {16'd0, c0};
        exp_ovf = (a[15] == bb[15]) && (full[15] != a[15]);

        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        A = a; B = b; Cin = cin; sub_s = sub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        A = 16'($urandom); B = 16'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", n, 32'd4);
        check("sum", {16'd0, Sum}, {16'd0, full[15:0]});
        check("cout", {31'd0, Cout}, {31'd0, full[16]});
        check("ovf", {31'd0, Ovf}, {31'd0, exp_ovf});
        check("in_ready_done", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_drop", {31'd0, out_valid}, 32'd0);
        check("sum_hold_idle", {16'd0, Sum}, {16'd0, full[15:0]});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Cin = 1'b0; sub_s = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, Sum}, 32'd0);
        check("rst_cout", {31'd0, Cout}, 32'd0);
        check("rst_ovf", {31'd0, Ovf}, 32'd0);

        // Directed boundary cases
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0);

        // Backpressure in DONE with a competing operand on the input side
        A = 16'h1234; B = 16'h4321; Cin = 1'b0; sub_s = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        A = 16'hAAAA; B = 16'hAAAA; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_sum", {16'd0, Sum}, 32'h5555);
            check("bp_cout", {31'd0, Cout}, 32'd0);
            check("bp_ovf", {31'd0, Ovf}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of RUN discards the operation
        A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_sum", {16'd0, Sum}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("midrst_no_out", {31'd0, out_valid}, 32'd0);
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0);

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1);
`endif

        // Random operands against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            logic sb;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
            sb = 1'($urandom);
`else
            sb = 1'b0;
`endif
            run_op(16'($urandom), 16'($urandom), 1'($urandom), sb);
            if ($urandom_range(0, 2) == 0) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Multi-cycle adder. Takes two WIDTH-bit operands and adds them DIGIT bits per clock, LSB digit first.
- A registered carry links each digit to the next.
- Datapath per cycle is a DIGIT-bit ripple chain of full_adder cells.
- Sits between operand producers and result consumers, with valid/ready handshakes on both sides. It trades latency for area against a full-width combinational ripple adder.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be ≥ 1.
- DIGIT, 4, bits processed per cycle. Must divide WIDTH; elaboration fails otherwise.
- NDIG (localparam), WIDTH/DIGIT, cycles per operation.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in to bit 0.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- Sum  output  WIDTH  result.
- Cout  output  1  carry out of bit WIDTH-1.
- Ovf  output  1  two's-complement overflow.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst sampled high at a clk edge):
  - State goes to IDLE; digit counter = 0; carry register = 0.
  - Sum = 0, Cout = 0, Ovf = 0, out_valid = 0, in_ready = 1.
  - Applies in any state, including mid-RUN; the operation in flight is discarded with no output.
- State IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready at an edge: capture A, B into operand shift registers and Cin into the carry register; clear the counter; go to RUN.
- State RUN:
  - in_ready = 0, out_valid = 0.
  - Each edge: add the low DIGIT bits of the A and B shift registers plus the carry register.
  - The DIGIT-bit digit sum shifts into the top of the Sum shift register (right shift). Carry register takes the digit carry-out. Operand registers shift right by DIGIT. Counter increments.
  - At the edge that processes digit NDIG-1: go to DONE.
  - At that same edge: Cout takes the final carry; Ovf takes (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
- State DONE:
  - out_valid = 1, in_ready = 0.
  - Sum, Cout and Ovf are held stable until handshake.
  - On out_ready at an edge: go to IDLE. Sum, Cout and Ovf keep their values; out_valid drops.
  - No same-cycle re-accept: a new operand is accepted at the earliest one cycle after leaving DONE.
- Latency: out_valid rises NDIG cycles after the accept edge. Throughput is one result per NDIG+2 cycles at best.
- Widths: no truncation beyond WIDTH. Carry chain is exact modulo 2^WIDTH with Cout as bit WIDTH.
- in_valid, A and B are ignored outside IDLE.
- DIGIT = WIDTH is legal: NDIG = 1, one RUN cycle.
- Sum is not a live view during RUN; it is only meaningful while out_valid = 1.

Optional Feature:
- Macro: DIGIT_SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port Sub (1 bit), sampled at accept.
  - Sub = 1: B is captured inverted and the carry register is loaded with 1 (Cin is ignored), computing A − B.
  - Cout = 1 means no borrow. Ovf is the signed subtraction overflow.
  - Sub = 0: behaviour is identical to plain add.
- Undefined: the Sub port is absent; add only.

Test Plan (WIDTH=16, DIGIT=4):
1. A=0x1234, B=0x1111, Cin=0, out_ready=1 → out_valid high exactly 4 cycles after accept edge; Sum=0x2345, Cout=0, Ovf=0.
2. A=0xFFFF, B=0x0001, Cin=0 → Sum=0x0000, Cout=1, Ovf=0. Then A=0x0000, B=0x0000, Cin=1 → Sum=0x0001, Cout=0.
3. A=0x7FFF, B=0x0001 → Sum=0x8000, Cout=0, Ovf=1. A=0x8000, B=0x8000 → Sum=0x0000, Cout=1, Ovf=1.
4. Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1, A=0xAAAA → Sum, Cout, Ovf and out_valid stable; in_ready=0; 0xAAAA never accepted. out_ready=1 → IDLE next cycle, in_ready=1.
5. Assert rst for one cycle after 2 RUN cycles → next cycle IDLE, out_valid=0, Sum=0, in_ready=1. A following op with A=0x0003, B=0x0004 gives Sum=0x0007.
6. With DIGIT_SERIAL_ADDER_SUB_EN: A=0x0005, B=0x0007, Sub=1 → Sum=0xFFFE, Cout=0, Ovf=0. A=0x8000, B=0x0001, Sub=1 → Sum=0x7FFF, Cout=1, Ovf=1.
